// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
//   Shared types and elaboration-time helpers for the serial MAC neuron.
//   - state_t   : controller states IDLE -> MAC -> ACT -> OUT
//   - clog2     : ceiling log2, usable in constant expressions
//   - ceil_div  : integer ceiling division (beats per vector)
//   - min_acc_w : smallest accumulator width that cannot overflow for a
//                 given operand width and input count (bias included)
// ---------------------------------------------------------------------------
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ACT,
        OUT
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // N_IN products plus the bias term: N_IN+1 signed 2*DW values summed.
    function automatic int min_acc_w(input int dw, input int n_in);
        return 2 * dw + clog2(n_in + 1);
    endfunction

endpackage

// File: rtl/nn_mac_slice.sv
// ---------------------------------------------------------------------------
// nn_mac_slice
//   Combinational multiply/add slice: LANES signed DW x DW products, each
//   sign-extended to ACC_W and summed.
// Ports
//   act  in  LANES*DW  packed signed activations, lane l at [l*DW +: DW]
//   wt   in  LANES*DW  packed signed weights,     lane l at [l*DW +: DW]
//   sum  out ACC_W     signed sum of the LANES products
// ---------------------------------------------------------------------------
module nn_mac_slice #(
    parameter int DW    = 8,
    parameter int LANES = 1,
    parameter int ACC_W = 20
) (
    input  logic [LANES*DW-1:0]     act,
    input  logic [LANES*DW-1:0]     wt,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [2*DW-1:0] prod [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign prod[l] = $signed(act[l*DW +: DW]) * $signed(wt[l*DW +: DW]);
    end

    always_comb begin
        sum = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            sum = sum + ACC_W'(prod[l]);
        end
    end

endmodule

// File: rtl/neuron_serial_mac.sv
// ---------------------------------------------------------------------------
// neuron_serial_mac
//   Fully-connected neuron: bias + sum(act[i]*w[i]) over N_IN signed inputs,
//   LANES products per cycle over K = ceil(N_IN/LANES) beats, then an
//   arithmetic right shift, ReLU and requantisation to OUT_W unsigned bits.
//   Valid/ready on both sides; one vector in flight at a time.
//
//   Build option: NEURON_SAT_EN
//     defined   - positive results above 2^OUT_W-1 clamp to all ones
//     undefined - positive results keep their low OUT_W bits (wrap)
//
// Ports
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous, active-high
//   in_valid   in   1          act_in holds a valid vector
//   in_ready   out  1          vector can be accepted (IDLE only)
//   act_in     in   N_IN*DW    packed signed activations, i at [i*DW +: DW]
//   out_valid  out  1          out_data holds a result
//   out_ready  in   1          downstream takes out_data
//   out_data   out  OUT_W      ReLU'd, requantised neuron output
// ---------------------------------------------------------------------------
module neuron_serial_mac
    import neuron_pkg::*;
#(
    parameter int                 N_IN      = 15,
    parameter int                 DW        = 8,
    parameter int                 LANES     = 1,
    parameter int                 ACC_W     = 20,
    parameter int                 OUT_W     = 16,
    parameter int                 OUT_SHIFT = 0,
    parameter logic [N_IN*DW-1:0] WEIGHTS   = '0,
    parameter logic signed [DW-1:0] BIAS    = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*DW-1:0]   act_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data
);

    localparam int K  = ceil_div(N_IN, LANES);
    localparam int BW = (clog2(K) < 1) ? 1 : clog2(K);
    localparam int PW = K * LANES * DW;

    // Weights padded to a whole number of beats; padding lanes are zero so
    // indices >= N_IN contribute nothing.
    localparam logic [PW-1:0]          W_PAD    = PW'(WEIGHTS);
    localparam logic signed [ACC_W-1:0] BIAS_EXT = ACC_W'(BIAS);

    if (LANES < 1 || LANES > N_IN) begin : g_bad_lanes
        $error("neuron_serial_mac: LANES must be in 1..N_IN");
    end
    if (ACC_W < min_acc_w(DW, N_IN)) begin : g_bad_acc_w
        $error("neuron_serial_mac: ACC_W too small for DW and N_IN");
    end
    if (OUT_W >= ACC_W) begin : g_bad_out_w
        $error("neuron_serial_mac: OUT_W must be smaller than ACC_W");
    end

    state_t                  state, state_n;
    logic [N_IN*DW-1:0]      act_reg;
    logic [PW-1:0]           act_pad;
    logic [LANES*DW-1:0]     act_lane, wt_lane;
    logic signed [ACC_W-1:0] acc, slice_sum, s;
    logic [BW-1:0]           beat;
    logic                    last_beat;
    logic [OUT_W-1:0]        act_val;

    always_comb begin
        act_pad                = '0;
        act_pad[N_IN*DW-1:0]   = act_reg;
    end

    assign act_lane  = act_pad[int'(beat)*LANES*DW +: LANES*DW];
    assign wt_lane   = W_PAD[int'(beat)*LANES*DW +: LANES*DW];
    assign last_beat = (beat == BW'(K - 1));

    nn_mac_slice #(
        .DW    (DW),
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) u_slice (
        .act (act_lane),
        .wt  (wt_lane),
        .sum (slice_sum)
    );

    // ReLU on the full-width sign bit, then clamp or wrap into OUT_W bits.
    assign s = acc >>> OUT_SHIFT;

    always_comb begin
        act_val = '0;
        if (!s[ACC_W-1]) begin
`ifdef NEURON_SAT_EN
            if (s > $signed(ACC_W'({OUT_W{1'b1}}))) begin
                act_val = '1;
            end else begin
                act_val = OUT_W'(s);
            end
`else
            act_val = OUT_W'(s);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = MAC;
                end
            end
            MAC: begin
                if (last_beat) begin
                    state_n = ACT;
                end
            end
            ACT: begin
                state_n = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_reg   <= '0;
            acc       <= '0;
            beat      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        act_reg <= act_in;
                        acc     <= BIAS_EXT;
                        beat    <= '0;
                    end
                end
                MAC: begin
                    acc  <= acc + slice_sum;
                    // Return to zero after the final beat so the lane
                    // select never points past the padded vector.
                    beat <= last_beat ? '0 : beat + 1'b1;
                end
                ACT: begin
                    out_data  <= act_val;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_serial_mac.sv
// ---------------------------------------------------------------------------
// tb_neuron_serial_mac
//   Four neuron instances with different shapes share one clock and reset.
//   Expected results come from an integer model of the neuron equation.
// ---------------------------------------------------------------------------
module tb_neuron_serial_mac;

    localparam int ND   = 4;
    localparam int MAXN = 7;

`ifdef NEURON_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef int vec_t [MAXN];

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [ND-1:0]   in_valid = '0;
    logic [ND-1:0]   in_ready;
    logic [ND-1:0]   out_valid;
    logic [ND-1:0]   out_ready = '0;
    logic [MAXN*8-1:0] act [ND];
    logic [15:0]     od0, od1;
    logic [7:0]      od2, od3;
    logic [15:0]     od [ND];

    // Instance configurations as seen by the model.
    int n_in  [ND]       = '{4, 4, 4, 7};
    int lanes [ND]       = '{1, 3, 1, 2};
    int ow    [ND]       = '{16, 16, 8, 8};
    int sh    [ND]       = '{0, 0, 0, 2};
    int bias  [ND]       = '{5, 5, 5, -20};
    int wt    [ND][MAXN] = '{'{1, 2, 3, 4, 0, 0, 0},
                             '{1, 2, 3, 4, 0, 0, 0},
                             '{127, 127, 127, 127, 0, 0, 0},
                             '{-128, 127, -3, 50, 1, -77, 99}};

    int exp_q [ND][$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        od[0] = od0;
        od[1] = od1;
        od[2] = {8'h00, od2};
        od[3] = {8'h00, od3};
    end

    neuron_serial_mac #(
        .N_IN(4), .DW(8), .LANES(1), .ACC_W(20), .OUT_W(16), .OUT_SHIFT(0),
        .WEIGHTS(32'h04_03_02_01), .BIAS(8'sd5)
    ) u_d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .act_in(act[0][31:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(od0)
    );

    neuron_serial_mac #(
        .N_IN(4), .DW(8), .LANES(3), .ACC_W(20), .OUT_W(16), .OUT_SHIFT(0),
        .WEIGHTS(32'h04_03_02_01), .BIAS(8'sd5)
    ) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .act_in(act[1][31:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(od1)
    );

    neuron_serial_mac #(
        .N_IN(4), .DW(8), .LANES(1), .ACC_W(20), .OUT_W(8), .OUT_SHIFT(0),
        .WEIGHTS(32'h7F_7F_7F_7F), .BIAS(8'sd5)
    ) u_d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .act_in(act[2][31:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(od2)
    );

    neuron_serial_mac #(
        .N_IN(7), .DW(8), .LANES(2), .ACC_W(20), .OUT_W(8), .OUT_SHIFT(2),
        .WEIGHTS(56'h63_B3_01_32_FD_7F_80), .BIAS(8'hEC)
    ) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .act_in(act[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_data(od3)
    );

    // Neuron equation in plain integer arithmetic.
    function automatic int model(input int d, input vec_t a);
        longint acc;
        longint s;
        longint mx;
        acc = bias[d];
        for (int i = 0; i < n_in[d]; i++) begin
            acc = acc + longint'(a[i]) * longint'(wt[d][i]);
        end
        s  = acc >>> sh[d];
        mx = (longint'(1) << ow[d]) - 1;
        if (s < 0) return 0;
        if (s > mx) return SAT ? int'(mx) : int'(s & mx);
        return int'(s);
    endfunction

    function automatic int k_of(input int d);
        return (n_in[d] + lanes[d] - 1) / lanes[d];
    endfunction

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Every cycle a result is presented it must match the oldest accepted
    // vector, and no new vector may be offered.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < ND; d++) begin
                if (out_valid[d]) begin
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        errors++;
                        $display("FAIL spurious_out dut%0d: out_valid=1 data %0d, expected no result",
                                 d, od[d]);
                    end else if (int'(od[d]) != exp_q[d][0]) begin
                        errors++;
                        $display("FAIL out_data dut%0d: got %0d, expected %0d",
                                 d, od[d], exp_q[d][0]);
                    end
                    checks++;
                    if (in_ready[d]) begin
                        errors++;
                        $display("FAIL overlap dut%0d: in_ready=1 while out_valid, expected 0", d);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            for (int d = 0; d < ND; d++) begin
                if (out_valid[d] && out_ready[d] && exp_q[d].size() > 0) begin
                    void'(exp_q[d].pop_front());
                end
            end
        end
    end

    task automatic accept(input int d, input vec_t a, output bit ok);
        int cnt;
        @(negedge clk);
        act[d] = '0;
        for (int i = 0; i < n_in[d]; i++) begin
            act[d][i*8 +: 8] = 8'(a[i]);
        end
        in_valid[d] = 1'b1;
        cnt = 0;
        while (!in_ready[d] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready[d]) begin
            check("in_ready_timeout", 0, 1);
            in_valid[d] = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q[d].push_back(model(d, a));
        #1 in_valid[d] = 1'b0;
        ok = 1'b1;
    endtask

    task automatic finish(input int d, input int hold, output int data, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid[d] && lat < 100);
        if (!out_valid[d]) begin
            check("out_valid_timeout", 0, 1);
            data = -1;
            return;
        end
        data = int'(od[d]);
        repeat (hold) @(negedge clk);
        check("held_valid", int'(out_valid[d]), 1);
        check("held_data", int'(od[d]), data);
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1 out_ready[d] = 1'b0;
        check("idle_in_ready", int'(in_ready[d]), 1);
        check("out_valid_drop", int'(out_valid[d]), 0);
    endtask

    task automatic run(input int d, input vec_t a, input int hold,
                       output int data, output int lat);
        bit ok;
        accept(d, a, ok);
        if (ok) begin
            finish(d, hold, data, lat);
        end else begin
            data = -1;
            lat  = -1;
        end
    endtask

    initial begin
        int   data, lat;
        bit   ok;
        vec_t ones, neg10, all127, v;

        ones   = '{1, 1, 1, 1, 0, 0, 0};
        neg10  = '{-10, 0, 0, 0, 0, 0, 0};
        all127 = '{127, 127, 127, 127, 0, 0, 0};
        for (int d = 0; d < ND; d++) act[d] = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check("reset_out_valid", int'(out_valid[d]), 0);
            check("reset_out_data", int'(od[d]), 0);
            check("reset_in_ready", int'(in_ready[d]), 1);
        end
        reset = 1'b0;

        // Model pinned against hand-worked values.
        check("model_ones", model(0, ones), 15);
        check("model_neg", model(0, neg10), 0);
        check("model_sat", model(2, all127), SAT ? 255 : 9);

        // Basic result and latency.
        run(0, ones, 0, data, lat);
        check("t1_data", data, 15);
        check("t1_latency", lat, 5);

        // Negative sum -> ReLU zero.
        run(0, neg10, 0, data, lat);
        check("t2_data", data, 0);

        // Over-range positive result: clamp or wrap.
        run(2, all127, 0, data, lat);
        check("t3_data", data, SAT ? 255 : 9);

        // Backpressure for 10 cycles.
        run(0, ones, 10, data, lat);
        check("t4_data", data, 15);

        // Reset during the second MAC beat abandons the vector.
        accept(0, ones, ok);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q[0].delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_no_valid", int'(out_valid[0]), 0);
        check("t5_in_ready", int'(in_ready[0]), 1);
        run(0, ones, 0, data, lat);
        check("t5_after_data", data, 15);

        // Multi-lane instance, K = 2.
        run(1, ones, 0, data, lat);
        check("t6_data", data, 15);
        check("t6_latency", lat, 3);
        run(1, neg10, 1, data, lat);
        check("t6_neg_data", data, 0);

        // Boundary activations on the shifted, 7-input instance.
        for (int i = 0; i < MAXN; i++) v[i] = 127;
        run(3, v, 0, data, lat);
        check("edge_pos", data, model(3, v));
        for (int i = 0; i < MAXN; i++) v[i] = -128;
        run(3, v, 0, data, lat);
        check("edge_neg", data, model(3, v));

        // Random vectors across all instances.
        for (int it = 0; it < 80; it++) begin
            int d;
            d = int'($urandom_range(0, ND - 1));
            for (int i = 0; i < MAXN; i++) v[i] = int'($urandom_range(0, 255)) - 128;
            run(d, v, int'($urandom_range(0, 3)), data, lat);
            check("rand_data", data, model(d, v));
            check("rand_latency", lat, k_of(d) + 1);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
